m_memarb: RTL and testbench

- Three-port arbiter that shares one single-port synchronous memory (1-cycle read latency, write-on-clock) between three requesters: the MEM-stage data port (D), the IF-stage instruction port (I) and a loader/debug port (L).
- Lets the pipeline run on a unified instruction/data memory, and lets a loader fill or inspect memory while the processor is halted.
- Fixed priority D > I > L, with a starvation guard that temporarily promotes I over D.

---
 rtl/m_memarb.sv | 103 ++++++++++
 tb/tb_m_memarb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_memarb.sv
// Three-port arbiter (D > I > L) in front of one single-port synchronous memory,
// with a wait counter that lifts I above D after MAX_WAIT denied cycles.
module m_memarb #(
    parameter int unsigned AW       = 12,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          w_clk,
    input  logic          w_rst,
    input  logic          w_d_req,
    input  logic          w_d_we,
    input  logic [AW-1:0] w_d_addr,
    input  logic [DW-1:0] w_d_din,
    output logic          w_d_gnt,
    output logic          r_d_rvalid,
    input  logic          w_i_req,
    input  logic [AW-1:0] w_i_addr,
    output logic          w_i_gnt,
    output logic          r_i_rvalid,
    input  logic          w_l_req,
    input  logic          w_l_we,
    input  logic [AW-1:0] w_l_addr,
    input  logic [DW-1:0] w_l_din,
    output logic          w_l_gnt,
    output logic          r_l_rvalid,
    output logic [DW-1:0] w_rdata,
    output logic [AW-1:0] r_mem_addr,
    output logic          r_mem_we,
    output logic [DW-1:0] r_mem_din,
    input  logic [DW-1:0] w_mem_dout
);

    localparam logic [1:0] IdD = 2'd0;
    localparam logic [1:0] IdI = 2'd1;
    localparam logic [1:0] IdL = 2'd2;
    localparam logic [3:0] WaitMax = 4'(MAX_WAIT);

    logic [3:0] r_wait;
    logic       r_tag_v;
    logic [1:0] r_tag_id;
    logic       i_prio;
    logic       d_xfer, i_xfer, l_xfer;

    assign i_prio = w_i_req && (r_wait == WaitMax);

    always_comb begin
        w_d_gnt = 1'b0;
        w_i_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (!w_rst) begin
            if (i_prio)       w_i_gnt = 1'b1;
            else if (w_d_req) w_d_gnt = 1'b1;
            else if (w_i_req) w_i_gnt = 1'b1;
            else if (w_l_req) w_l_gnt = 1'b1;
        end
    end

    assign d_xfer  = w_d_req && w_d_gnt;
    assign i_xfer  = w_i_req && w_i_gnt;
    assign l_xfer  = w_l_req && w_l_gnt;
    assign w_rdata = w_mem_dout;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_wait     <= '0;
            r_tag_v    <= 1'b0;
            r_tag_id   <= '0;
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_mem_din  <= '0;
            r_d_rvalid <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_l_rvalid <= 1'b0;
        end else begin
            if (i_xfer || !w_i_req) begin
                r_wait <= '0;
            end else if (r_wait != WaitMax) begin
                r_wait <= r_wait + 4'd1;
            end

            r_mem_we <= 1'b0;
            if (d_xfer) begin
                r_mem_addr <= w_d_addr;
                r_mem_din  <= w_d_din;
                r_mem_we   <= w_d_we;
            end else if (i_xfer) begin
                r_mem_addr <= w_i_addr;
            end else if (l_xfer) begin
                r_mem_addr <= w_l_addr;
                r_mem_din  <= w_l_din;
                r_mem_we   <= w_l_we;
            end

            // Stage 1 tracks the command in the memory; stage 2 is the decoded rvalid.
            r_tag_v    <= (d_xfer && !w_d_we) || i_xfer || (l_xfer && !w_l_we);
            r_tag_id   <= d_xfer ? IdD : (i_xfer ? IdI : IdL);
            r_d_rvalid <= r_tag_v && (r_tag_id == IdD);
            r_i_rvalid <= r_tag_v && (r_tag_id == IdI);
            r_l_rvalid <= r_tag_v && (r_tag_id == IdL);
        end
    end

endmodule

// File: tb/tb_m_memarb.sv
// Directed bench for m_memarb: expected grants checked per cycle, expected read data
// queued at issue and compared by an independent monitor when rvalid appears.
module tb_m_memarb;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          w_clk = 1'b0;
    logic          w_rst;
    logic          w_d_req, w_d_we, w_d_gnt, r_d_rvalid;
    logic [AW-1:0] w_d_addr;
    logic [DW-1:0] w_d_din;
    logic          w_i_req, w_i_gnt, r_i_rvalid;
    logic [AW-1:0] w_i_addr;
    logic          w_l_req, w_l_we, w_l_gnt, r_l_rvalid;
    logic [AW-1:0] w_l_addr;
    logic [DW-1:0] w_l_din;
    logic [DW-1:0] w_rdata;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_din;
    logic [DW-1:0] w_mem_dout;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    m_memarb #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_d_req    (w_d_req),
        .w_d_we     (w_d_we),
        .w_d_addr   (w_d_addr),
        .w_d_din    (w_d_din),
        .w_d_gnt    (w_d_gnt),
        .r_d_rvalid (r_d_rvalid),
        .w_i_req    (w_i_req),
        .w_i_addr   (w_i_addr),
        .w_i_gnt    (w_i_gnt),
        .r_i_rvalid (r_i_rvalid),
        .w_l_req    (w_l_req),
        .w_l_we     (w_l_we),
        .w_l_addr   (w_l_addr),
        .w_l_din    (w_l_din),
        .w_l_gnt    (w_l_gnt),
        .r_l_rvalid (r_l_rvalid),
        .w_rdata    (w_rdata),
        .r_mem_addr (r_mem_addr),
        .r_mem_we   (r_mem_we),
        .r_mem_din  (r_mem_din),
        .w_mem_dout (w_mem_dout)
    );

    always #5 w_clk = ~w_clk;

    // Single-port synchronous memory, loaded on the first edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            loaded = 1'b0;
    always @(posedge w_clk) begin
        if (!loaded) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'hC0DE0000 | 32'(i);
            mem[5] <= 32'h20010020;
            loaded <= 1'b1;
            w_mem_dout <= '0;
        end else begin
            if (r_mem_we) mem[r_mem_addr] <= r_mem_din;
            w_mem_dout <= mem[r_mem_addr];
        end
    end

    // Monitor: every rvalid must match the oldest queued expectation.
    always @(negedge w_clk) begin
        logic [2:0] rv;
        exp_t       e;
        rv = {r_l_rvalid, r_i_rvalid, r_d_rvalid};
        if (rv != 3'b000) begin
            n_chk++;
            if ($countones(rv) != 1 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected: rvalid {l,i,d}=%b, queued=%0d", rv, sb.size());
            end else begin
                e = sb.pop_front();
                if (rv != (3'b001 << e.id) || w_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL read_return: rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                             rv, w_rdata, 3'b001 << e.id, e.data);
                end
            end
        end
    end

    task automatic step(input logic [2:0] exp, input logic rd, input logic [31:0] data,
                        input string nm);
        exp_t e;
        @(negedge w_clk);
        n_chk++;
        if ({w_l_gnt, w_i_gnt, w_d_gnt} !== exp) begin
            n_fail++;
            $display("FAIL %s: grants {l,i,d}=%b, expected %b", nm,
                     {w_l_gnt, w_i_gnt, w_d_gnt}, exp);
        end
        if (rd) begin
            e.id   = exp[0] ? 2'd0 : (exp[1] ? 2'd1 : 2'd2);
            e.data = data;
            sb.push_back(e);
        end
        @(posedge w_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(3'b000, 1'b0, '0, "idle");
    endtask

    task automatic check(input logic [63:0] act, input logic [63:0] req, input string nm);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    localparam logic [2:0] GD = 3'b001;
    localparam logic [2:0] GI = 3'b010;
    localparam logic [2:0] GL = 3'b100;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        w_rst = 1'b1;
        w_d_req = 1'b1; w_d_we = 1'b0; w_d_addr = '0; w_d_din = '0;
        w_i_req = 1'b1; w_i_addr = '0;
        w_l_req = 1'b1; w_l_we = 1'b0; w_l_addr = '0; w_l_din = '0;

        // Reset: grants forced low, registered outputs zero.
        @(negedge w_clk);
        check(64'({w_l_gnt, w_i_gnt, w_d_gnt}), 64'd0, "reset_grants");
        check(64'({r_mem_addr, r_mem_we, r_mem_din, r_d_rvalid, r_i_rvalid, r_l_rvalid}),
              64'd0, "reset_outputs");
        @(posedge w_clk);
        #1;
        w_rst = 1'b0; w_d_req = 1'b0; w_i_req = 1'b0; w_l_req = 1'b0;

        // Single I read of address 5.
        w_i_req = 1'b1; w_i_addr = 12'd5;
        step(GI, 1'b1, 32'h20010020, "i_single");
        w_i_req = 1'b0;
        idle(3);

        // D write then D read of the same address.
        w_d_req = 1'b1; w_d_we = 1'b1; w_d_addr = 12'h010; w_d_din = 32'hDEADBEEF;
        step(GD, 1'b0, '0, "d_write");
        check(64'({r_mem_we, r_mem_addr, r_mem_din}), 64'({1'b1, 12'h010, 32'hDEADBEEF}),
              "write_cmd");
        w_d_we = 1'b0; w_d_din = '0;
        step(GD, 1'b1, 32'hDEADBEEF, "d_read_after_write");
        check(64'({r_mem_we, r_mem_addr}), 64'({1'b0, 12'h010}), "we_one_cycle");
        w_d_req = 1'b0;
        idle(3);

        // D and I contend: starvation guard gives D,D,D,D,I twice.
        w_d_req = 1'b1; w_d_addr = 12'h020;
        w_i_req = 1'b1; w_i_addr = 12'd5;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) step(GD, 1'b1, 32'hC0DE0020, "contend_d");
            step(GI, 1'b1, 32'h20010020, "contend_i");
        end
        w_d_req = 1'b0; w_i_req = 1'b0;
        idle(3);

        // All three at once, winners drop out: D, I, L.
        w_d_req = 1'b1; w_d_addr = 12'h021;
        w_i_req = 1'b1; w_i_addr = 12'h022;
        w_l_req = 1'b1; w_l_we = 1'b0; w_l_addr = 12'h030;
        step(GD, 1'b1, 32'hC0DE0021, "all3_d");
        w_d_req = 1'b0;
        step(GI, 1'b1, 32'hC0DE0022, "all3_i");
        w_i_req = 1'b0;
        step(GL, 1'b1, 32'hC0DE0030, "all3_l");
        w_l_req = 1'b0;
        idle(3);

        // Reset while an I read is in flight: no return, outputs zero, grants resume.
        w_i_req = 1'b1; w_i_addr = 12'd5;
        step(GI, 1'b0, '0, "i_before_reset");
        w_i_req = 1'b0;
        w_rst = 1'b1;
        w_d_req = 1'b1; w_d_we = 1'b0; w_d_addr = 12'h010;
        @(negedge w_clk);
        check(64'({w_l_gnt, w_i_gnt, w_d_gnt}), 64'd0, "midreset_grants");
        check(64'({r_mem_addr, r_mem_we, r_mem_din, r_d_rvalid, r_i_rvalid, r_l_rvalid}),
              64'd0, "midreset_outputs");
        @(posedge w_clk);
        #1;
        w_rst = 1'b0;
        step(GD, 1'b1, 32'hDEADBEEF, "after_reset_d");
        w_d_req = 1'b0;
        idle(3);

        // Streaming I reads of addresses 1..4.
        w_i_req = 1'b1;
        for (int a = 1; a <= 4; a++) begin
            w_i_addr = 12'(a);
            step(GI, 1'b1, 32'hC0DE0000 | 32'(a), "i_stream");
        end
        w_i_req = 1'b0;
        idle(4);

        check(64'(sb.size()), 64'd0, "all_reads_returned");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
